// File: rtl/jk_reg_bank.sv
// jk_reg_bank -- bank of WIDTH independent flip-flops that behave as JK, SR, T or D
// flip-flops, selected at run time by a shared mode input.
//
// Optional feature: define JK_TOGGLE_CNT_EN to add the saturating 16-bit
// change counter and its toggle_cnt output port.
//
// Parameters
//   WIDTH      number of flip-flop bits (1..32)
//   RESET_VAL  value loaded into q on reset and on sync_clr
// Ports
//   clk         clock, all state changes on its rising edge
//   reset       asynchronous active-high reset
//   en          update enable (0 = every bit holds, mode ignored)
//   sync_clr    synchronous clear of q/qb/err/toggle_cnt, wins over en
//   mode        00 JK, 01 SR, 10 T, 11 D
//   j           per-bit J / S / T / D input
//   k           per-bit K / R input (unused in T and D modes)
//   err_clr     clears the sticky err flag
//   q, qb       registered state and its registered complement
//   err         sticky flag: an SR-mode bit saw S=R=1 while enabled
//   toggle_cnt  count of enabled edges that changed q (JK_TOGGLE_CNT_EN only)
module jk_reg_bank #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             err
`ifdef JK_TOGGLE_CNT_EN
  ,
  output logic [15:0]      toggle_cnt
`endif
);

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_SR = 2'b01;
  localparam logic [1:0] MODE_T  = 2'b10;
  localparam logic [1:0] MODE_D  = 2'b11;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] qb_reg;
  logic             err_reg;
  logic [WIDTH-1:0] q_upd;
  logic [WIDTH-1:0] q_next;
  logic             err_next;
  logic             sr_violation;

  // Per-bit next state for the selected flip-flop type, assuming en=1.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic bit_next;
    always_comb begin
      bit_next = q_reg[gi];
      case (mode)
        MODE_JK: begin
          case ({j[gi], k[gi]})
            2'b01:   bit_next = 1'b0;
            2'b10:   bit_next = 1'b1;
            2'b11:   bit_next = ~q_reg[gi];
            default: bit_next = q_reg[gi];
          endcase
        end
        MODE_SR: begin
          // S=R=1 is illegal: the bit holds and err is raised instead.
          case ({j[gi], k[gi]})
            2'b01:   bit_next = 1'b0;
            2'b10:   bit_next = 1'b1;
            default: bit_next = q_reg[gi];
          endcase
        end
        MODE_T:  bit_next = j[gi] ? ~q_reg[gi] : q_reg[gi];
        MODE_D:  bit_next = j[gi];
        default: bit_next = q_reg[gi];
      endcase
    end
    assign q_upd[gi] = bit_next;
  end

  assign sr_violation = en && (mode == MODE_SR) && (|(j & k));

  always_comb begin
    q_next = q_reg;
    if (en) begin
      q_next = q_upd;
    end
  end

  // A new violation wins over err_clr in the same cycle.
  always_comb begin
    err_next = err_reg;
    if (sr_violation) begin
      err_next = 1'b1;
    end else if (err_clr) begin
      err_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg   <= RESET_VAL;
      qb_reg  <= ~RESET_VAL;
      err_reg <= 1'b0;
    end else if (sync_clr) begin
      q_reg   <= RESET_VAL;
      qb_reg  <= ~RESET_VAL;
      err_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      qb_reg  <= ~q_next;
      err_reg <= err_next;
    end
  end

  assign q   = q_reg;
  assign qb  = qb_reg;
  assign err = err_reg;

`ifdef JK_TOGGLE_CNT_EN
  logic [15:0] cnt_reg;
  logic [15:0] cnt_next;

  // Counts edges whose update actually changed q; sticks at all-ones.
  always_comb begin
    cnt_next = cnt_reg;
    if (en && (q_next != q_reg) && (cnt_reg != 16'hFFFF)) begin
      cnt_next = cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= 16'd0;
    end else if (sync_clr) begin
      cnt_reg <= 16'd0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign toggle_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
module tb_jk_reg_bank;

  localparam int unsigned      W  = 8;
  localparam logic [W-1:0]     RV = 8'h00;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         sync_clr = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] j = '0;
  logic [W-1:0] k = '0;
  logic         err_clr = 1'b0;
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic         err;
`ifdef JK_TOGGLE_CNT_EN
  logic [15:0]  toggle_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int n_tx   = 0;

  // Reference state
  logic [W-1:0] q_m;
  logic         err_m;
  int           cnt_m;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .sync_clr(sync_clr),
    .mode(mode),
    .j(j),
    .k(k),
    .err_clr(err_clr),
    .q(q),
    .qb(qb),
    .err(err)
`ifdef JK_TOGGLE_CNT_EN
    ,
    .toggle_cnt(toggle_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flip-flop characteristic equations, applied to the whole word at once.
  function automatic logic [W-1:0] ff_next(input logic [1:0] md, input logic [W-1:0] qc,
                                           input logic [W-1:0] jj, input logic [W-1:0] kk);
    logic [W-1:0] set_bits;
    logic [W-1:0] clr_bits;
    case (md)
      2'd0: return (jj & ~qc) | (~kk & qc);          // Q+ = J~Q + ~KQ
      2'd1: begin
        set_bits = jj & ~kk;
        clr_bits = kk & ~jj;
        return (qc | set_bits) & ~clr_bits;
      end
      2'd2: return qc ^ jj;
      default: return jj;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".q"}, {24'd0, q}, {24'd0, q_m});
    check({tag, ".qb"}, {24'd0, qb}, {24'd0, ~q_m});
    check({tag, ".err"}, {31'd0, err}, {31'd0, err_m});
`ifdef JK_TOGGLE_CNT_EN
    check({tag, ".cnt"}, {16'd0, toggle_cnt}, cnt_m);
`endif
  endtask

  // One clock edge: predict from the current inputs, clock, then compare.
  task automatic tick(input string tag);
    logic [W-1:0] qn;
    logic         en_n;
    en_n = err_m;
    if (sync_clr) begin
      qn    = RV;
      en_n  = 1'b0;
      cnt_m = 0;
    end else begin
      qn = en ? ff_next(mode, q_m, j, k) : q_m;
      if (en && (mode == 2'd1) && ((j & k) != 0)) en_n = 1'b1;
      else if (err_clr) en_n = 1'b0;
      if (qn != q_m && cnt_m < 65535) cnt_m = cnt_m + 1;
    end
    @(posedge clk);
    #1;
    q_m   = qn;
    err_m = en_n;
    n_tx++;
    $display("tx %0d %s: mode=%0d en=%0d clr=%0d eclr=%0d j=%h k=%h -> q=%h err=%0b",
             n_tx, tag, mode, en, sync_clr, err_clr, j, k, q, err);
    check_all(tag);
  endtask

  task automatic drive(input logic e, input logic [1:0] md, input logic [W-1:0] jj,
                       input logic [W-1:0] kk, input logic sc, input logic ec);
    en = e; mode = md; j = jj; k = kk; sync_clr = sc; err_clr = ec;
  endtask

  initial begin
    q_m = RV; err_m = 1'b0; cnt_m = 0;

    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #1 check_all("reset_async");
    #6 reset = 1'b0;
    $display("tx %0d reset: q=%h qb=%h err=%0b", n_tx, q, qb, err);

    // JK set/clear mix
    drive(1, 2'd0, 8'hF0, 8'h0F, 0, 0);
    tick("jk_setclr");
    // JK toggle twice
    drive(1, 2'd0, 8'hFF, 8'hFF, 0, 0);
    tick("jk_tog1");
    tick("jk_tog2");
    drive(1, 2'd0, 8'h00, 8'h00, 0, 0);
    tick("jk_hold");

    // SR illegal combination, err_clr race, then clear
    drive(1, 2'd1, 8'h01, 8'h01, 0, 0);
    tick("sr_viol");
    drive(1, 2'd1, 8'h01, 8'h01, 0, 1);
    tick("sr_viol_clr");
    drive(1, 2'd1, 8'h00, 8'h00, 0, 1);
    tick("sr_errclr");
    drive(1, 2'd1, 8'h0C, 8'h30, 0, 0);
    tick("sr_setclr");
    // Disabled SR violation must not raise err
    drive(0, 2'd1, 8'hFF, 8'hFF, 0, 0);
    tick("sr_dis");

    // D mode gated by en, then T mode
    drive(0, 2'd3, 8'hA5, 8'h00, 0, 0);
    tick("d_dis");
    en = 1'b1;
    tick("d_load");
    drive(1, 2'd2, 8'hFF, 8'h00, 0, 0);
    tick("t_all");
    drive(1, 2'd2, 8'h0F, 8'hFF, 0, 0);
    tick("t_low");

    // sync_clr beats an enabled update and clears err
    drive(1, 2'd1, 8'hFF, 8'hFF, 0, 0);
    tick("pre_clr_viol");
    drive(1, 2'd0, 8'hFF, 8'hFF, 1, 0);
    tick("sync_clr");

    // Randomised traffic against the reference
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 5) == 0));
      tick("rand");
    end

    // Reset pulse between edges, then first update on first edge after release
    drive(1, 2'd3, 8'h3C, 8'h00, 0, 0);
    tick("pre_rst");
    #2 reset = 1'b1;
    q_m = RV; err_m = 1'b0; cnt_m = 0;
    #1 check_all("reset_mid");
    #1 reset = 1'b0;
    drive(1, 2'd3, 8'h99, 8'h00, 0, 0);
    tick("post_rst");

`ifdef JK_TOGGLE_CNT_EN
    // Counter saturation
    force dut.cnt_reg = 16'hFFFE;
    #1 release dut.cnt_reg;
    cnt_m = 16'hFFFE;
    drive(1, 2'd2, 8'hFF, 8'h00, 0, 0);
    tick("sat1");
    tick("sat2");
    tick("sat3");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
